// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the tic-tac-toe move sequencer and the game core.
//   mark_t      : cell / player mark encoding (NONE, X, O)
//   win_t       : core win report (none, X wins, O wins, draw)
//   seq_state_t : sequencer FSM states
//   BOARD_DIM   : board edge length, shared with the game core
package ttt_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    X    = 2'b01,
    O    = 2'b10
  } mark_t;

  typedef enum logic [1:0] {
    NOWIN = 2'b00,
    XWIN  = 2'b01,
    OWIN  = 2'b10,
    DRAW  = 2'b11
  } win_t;

  typedef enum logic [2:0] {
    NEWG,
    IDLE,
    ISSUE,
    WAIT_RESP,
    AI_REQ,
    AI_WAIT,
    OVER
  } seq_state_t;

  localparam int unsigned BOARD_DIM = 3;
  localparam logic [3:0]  MAX_MOVES = 4'd9;

  // True when a row/column index lies on the board.
  function automatic logic in_board(input logic [1:0] idx);
    return 32'(idx) < BOARD_DIM;
  endfunction

  // Move counter increment, saturating at a full board.
  function automatic logic [3:0] count_inc(input logic [3:0] v);
    return (v >= MAX_MOVES) ? MAX_MOVES : v + 4'd1;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Bus between the move sequencer and the tic-tac-toe game core.
//   xoroin/rowin/colin : move presented to the core (xoroin = 00 means no move)
//   ai_en              : one-cycle AI move request
//   core_reset         : active-high synchronous core reset
//   err                : core rejected the move (cell occupied)
//   xoroout/rowout/colout : AI move reported by the core
//   win                : core win/draw report
// master = sequencer side, slave = core side.
interface move_sequencer_if;
  logic [1:0] xoroin;
  logic [1:0] rowin;
  logic [1:0] colin;
  logic       ai_en;
  logic       core_reset;
  logic       err;
  logic [1:0] xoroout;
  logic [1:0] rowout;
  logic [1:0] colout;
  logic [1:0] win;

  modport master (
    output xoroin, rowin, colin, ai_en, core_reset,
    input  err, xoroout, rowout, colout, win
  );

  modport slave (
    input  xoroin, rowin, colin, ai_en, core_reset,
    output err, xoroout, rowout, colout, win
  );
endinterface

// File: rtl/move_sequencer_timer.sv
// seq_timer: loadable down-counter with terminal-count flag.
//   clk, reset (async active-low)
//   load     : load load_val this cycle (wins over counting)
//   load_val : reload value
//   tc       : counter is at zero (counting stops there)
module seq_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: front-end of the tic-tac-toe core. Takes key presses and
// new-game requests, presents one move at a time to the core, samples the
// core's err/win response, and in single-player mode requests and waits for
// the core's AI (O) move.
//   clk, reset (async active-low)
//   key_valid/key_row/key_col : player key strobe and coordinates
//   new_game, single_player   : restart strobe, mode level (sampled on new_game)
//   core                      : bus to the game core (master side)
//   turn          : mark of the player to move
//   busy          : not in IDLE
//   move_rejected : one-cycle pulse on local or core rejection
//   key_dropped   : sticky, a key arrived while busy
//   move_count    : accepted moves this game (saturates at 9)
module move_sequencer
  import ttt_pkg::*;
#(
  parameter int unsigned RESP_LAT   = 1,
  parameter int unsigned AI_TIMEOUT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [1:0]       key_row,
  input  logic [1:0]       key_col,
  input  logic             new_game,
  input  logic             single_player,
  move_sequencer_if.master core,
  output logic [1:0]       turn,
  output logic             busy,
  output logic             move_rejected,
  output logic             key_dropped,
  output logic [3:0]       move_count
);

  seq_state_t state_q, state_d;

  mark_t      turn_q, turn_d;
  mark_t      xoroin_q, xoroin_d;
  logic [1:0] rowin_q, rowin_d;
  logic [1:0] colin_q, colin_d;
  logic       ai_en_q, ai_en_d;
  logic       core_reset_q, core_reset_d;
  logic       rejected_q, rejected_d;
  logic       dropped_q, dropped_d;
  logic [3:0] count_q, count_d;
  logic       single_q, single_d;

  logic             key_legal;
  logic             ai_moved;
  logic             win_seen;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;

  // AI move coordinates go straight to the board inside the core; only the
  // mark is needed here.
  logic ai_coord_unused;
  assign ai_coord_unused = ^{core.rowout, core.colout};

  assign key_legal = in_board(key_row) && in_board(key_col);
  assign ai_moved  = (core.xoroout == O);
  assign win_seen  = (core.win != NOWIN);

  // One timer serves both waits: loaded on entry to ISSUE with the response
  // latency so it hits zero exactly RESP_LAT cycles after the issue cycle,
  // and on entry to AI_REQ so AI_WAIT lasts at most AI_TIMEOUT cycles.
  assign tmr_load = (state_d == ISSUE) || (state_d == AI_REQ);
  assign tmr_val  = (state_d == ISSUE) ? CNT_W'(RESP_LAT) : CNT_W'(AI_TIMEOUT);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= NEWG;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NEWG: state_d = IDLE;
      IDLE: begin
        if (new_game)                    state_d = NEWG;
        else if (key_valid && key_legal) state_d = ISSUE;
      end
      ISSUE: state_d = new_game ? NEWG : WAIT_RESP;
      WAIT_RESP: begin
        if (new_game) state_d = NEWG;
        else if (tmr_tc) begin
          if (core.err)                    state_d = IDLE;
          else if (win_seen)               state_d = OVER;
          else if (single_q && turn_q == X) state_d = AI_REQ;
          else                             state_d = IDLE;
        end
      end
      AI_REQ: state_d = new_game ? NEWG : AI_WAIT;
      AI_WAIT: begin
        if (new_game)      state_d = NEWG;
        else if (ai_moved) state_d = win_seen ? OVER : IDLE;
        else if (tmr_tc)   state_d = IDLE;
      end
      OVER: if (new_game) state_d = NEWG;
      default: state_d = NEWG;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    turn_d     = turn_q;
    count_d    = count_q;
    dropped_d  = dropped_q;
    single_d   = single_q;
    rejected_d = 1'b0;

    // Core-facing strobes follow the state being entered, so they are high
    // for exactly the cycle spent in that state. ISSUE is only entered from
    // IDLE on a legal key, so the key coordinates are the registered move.
    xoroin_d     = (state_d == ISSUE) ? turn_q : NONE;
    rowin_d      = (state_d == ISSUE) ? key_row : '0;
    colin_d      = (state_d == ISSUE) ? key_col : '0;
    ai_en_d      = (state_d == AI_REQ);
    core_reset_d = (state_d == NEWG);

    if (key_valid && state_q != IDLE && state_q != NEWG) dropped_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!new_game && key_valid && !key_legal) rejected_d = 1'b1;
      end
      WAIT_RESP: begin
        if (!new_game && tmr_tc) begin
          if (core.err) begin
            rejected_d = 1'b1;
          end else begin
            count_d = count_inc(count_q);
            if (!win_seen) turn_d = (turn_q == X) ? O : X;
          end
        end
      end
      AI_WAIT: begin
        if (!new_game) begin
          if (ai_moved) begin
            count_d = count_inc(count_q);
            if (!win_seen) turn_d = X;
          end else if (tmr_tc) begin
            rejected_d = 1'b1;
            turn_d     = X;
          end
        end
      end
      default: ;
    endcase

    // Entering NEWG starts a fresh game; the mode is taken from the strobe.
    if (state_d == NEWG) begin
      count_d   = '0;
      dropped_d = 1'b0;
      turn_d    = X;
      if (new_game) single_d = single_player;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_q       <= X;
      xoroin_q     <= NONE;
      rowin_q      <= '0;
      colin_q      <= '0;
      ai_en_q      <= 1'b0;
      core_reset_q <= 1'b1;
      rejected_q   <= 1'b0;
      dropped_q    <= 1'b0;
      count_q      <= '0;
      single_q     <= 1'b0;
    end else begin
      turn_q       <= turn_d;
      xoroin_q     <= xoroin_d;
      rowin_q      <= rowin_d;
      colin_q      <= colin_d;
      ai_en_q      <= ai_en_d;
      core_reset_q <= core_reset_d;
      rejected_q   <= rejected_d;
      dropped_q    <= dropped_d;
      count_q      <= count_d;
      single_q     <= single_d;
    end
  end

  assign core.xoroin     = xoroin_q;
  assign core.rowin      = rowin_q;
  assign core.colin      = colin_q;
  assign core.ai_en      = ai_en_q;
  assign core.core_reset = core_reset_q;
  assign turn            = turn_q;
  assign busy            = (state_q != IDLE);
  assign move_rejected   = rejected_q;
  assign key_dropped     = dropped_q;
  assign move_count      = count_q;

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;
  import ttt_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic       new_game;
  logic       single_player;
  logic [1:0] turn;
  logic       busy;
  logic       move_rejected;
  logic       key_dropped;
  logic [3:0] move_count;

  move_sequencer_if core_bus ();

  move_sequencer #(.RESP_LAT(1), .AI_TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_row       (key_row),
    .key_col       (key_col),
    .new_game      (new_game),
    .single_player (single_player),
    .core          (core_bus),
    .turn          (turn),
    .busy          (busy),
    .move_rejected (move_rejected),
    .key_dropped   (key_dropped),
    .move_count    (move_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];   // expected {xoroin,rowin,colin} per issued move

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one key from IDLE; returns in the cycle after the core response.
  task automatic play(input logic [1:0] r, input logic [1:0] c, input logic e,
                      input logic [1:0] w, input logic [1:0] mark);
    key_valid = 1'b1; key_row = r; key_col = c;
    core_bus.err = e; core_bus.win = w;
    exp_q.push_back({mark, r, c});
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    core_bus.err = 1'b0; core_bus.win = 2'b00;
  endtask

  // Scoreboard: every move presented to the core must match the next expected one.
  always @(negedge clk) begin
    if (reset && core_bus.xoroin != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", {2'b00, core_bus.xoroin, core_bus.rowin, core_bus.colin}, 8'h00);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("issue", {2'b00, core_bus.xoroin, core_bus.rowin, core_bus.colin}, {2'b00, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    logic [1:0] mk;
    key_valid = 0; key_row = 0; key_col = 0;
    new_game = 0; single_player = 0;
    core_bus.err = 0; core_bus.xoroout = 0; core_bus.rowout = 0;
    core_bus.colout = 0; core_bus.win = 0;

    // Reset values
    #1 reset = 1'b0;
    tick(); tick();
    chk("rst_xoroin", {6'b0, core_bus.xoroin}, 8'h00);
    chk("rst_ai_en", {7'b0, core_bus.ai_en}, 8'h00);
    chk("rst_turn", {6'b0, turn}, 8'h01);
    chk("rst_busy", {7'b0, busy}, 8'h01);
    chk("rst_rej", {7'b0, move_rejected}, 8'h00);
    chk("rst_drop", {7'b0, key_dropped}, 8'h00);
    chk("rst_count", {4'b0, move_count}, 8'h00);
    reset = 1'b1;
    chk("rel_core_reset", {7'b0, core_bus.core_reset}, 8'h01);
    tick();
    chk("idle_core_reset", {7'b0, core_bus.core_reset}, 8'h00);
    chk("idle_busy", {7'b0, busy}, 8'h00);

    // Two-player: X plays (1,2)
    play(2'd1, 2'd2, 1'b0, 2'b00, 2'b01);
    chk("m1_turn", {6'b0, turn}, 8'h02);
    chk("m1_count", {4'b0, move_count}, 8'h01);
    chk("m1_busy", {7'b0, busy}, 8'h00);

    // Illegal key (3,0)
    key_valid = 1; key_row = 2'd3; key_col = 2'd0;
    tick();
    key_valid = 0;
    chk("ill_rej", {7'b0, move_rejected}, 8'h01);
    chk("ill_turn", {6'b0, turn}, 8'h02);
    chk("ill_busy", {7'b0, busy}, 8'h00);
    tick();
    chk("ill_rej_end", {7'b0, move_rejected}, 8'h00);

    // Core rejects O at occupied (1,2)
    play(2'd1, 2'd2, 1'b1, 2'b00, 2'b10);
    chk("err_rej", {7'b0, move_rejected}, 8'h01);
    chk("err_turn", {6'b0, turn}, 8'h02);
    chk("err_count", {4'b0, move_count}, 8'h01);
    tick();
    chk("err_rej_end", {7'b0, move_rejected}, 8'h00);

    // O plays (0,0), then X completes a line and the core reports X win
    play(2'd0, 2'd0, 1'b0, 2'b00, 2'b10);
    chk("m2_turn", {6'b0, turn}, 8'h01);
    play(2'd1, 2'd1, 1'b0, 2'b01, 2'b01);
    chk("win_busy", {7'b0, busy}, 8'h01);
    chk("win_turn", {6'b0, turn}, 8'h01);
    chk("win_count", {4'b0, move_count}, 8'h03);
    key_valid = 1; key_row = 2'd0; key_col = 2'd2;
    tick();
    key_valid = 0;
    chk("over_drop", {7'b0, key_dropped}, 8'h01);
    chk("over_count", {4'b0, move_count}, 8'h03);

    // New single-player game
    new_game = 1; single_player = 1;
    tick();
    new_game = 0;
    chk("ng_core_reset", {7'b0, core_bus.core_reset}, 8'h01);
    chk("ng_count", {4'b0, move_count}, 8'h00);
    chk("ng_drop", {7'b0, key_dropped}, 8'h00);
    chk("ng_turn", {6'b0, turn}, 8'h01);
    tick();
    chk("ng_core_reset_end", {7'b0, core_bus.core_reset}, 8'h00);

    // X (0,0), AI answers three cycles after ai_en
    play(2'd0, 2'd0, 1'b0, 2'b00, 2'b01);
    chk("sp_ai_en", {7'b0, core_bus.ai_en}, 8'h01);
    chk("sp_turn_o", {6'b0, turn}, 8'h02);
    chk("sp_count1", {4'b0, move_count}, 8'h01);
    tick();
    chk("sp_ai_en_end", {7'b0, core_bus.ai_en}, 8'h00);
    tick();
    tick();
    core_bus.xoroout = 2'b10; core_bus.rowout = 2'd1; core_bus.colout = 2'd1;
    tick();
    core_bus.xoroout = 2'b00;
    chk("sp_turn_x", {6'b0, turn}, 8'h01);
    chk("sp_count2", {4'b0, move_count}, 8'h02);
    chk("sp_busy", {7'b0, busy}, 8'h00);

    // X (0,1), AI never answers: timeout after AI_TIMEOUT cycles
    play(2'd0, 2'd1, 1'b0, 2'b00, 2'b01);
    ticks = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      ticks++;
    end
    chk("to_cycles", 8'(ticks), 8'd17);
    chk("to_rej", {7'b0, move_rejected}, 8'h01);
    chk("to_turn", {6'b0, turn}, 8'h01);
    chk("to_count", {4'b0, move_count}, 8'h03);

    // new_game together with key_valid in IDLE: no issue, back to two-player
    new_game = 1; single_player = 0;
    key_valid = 1; key_row = 2'd1; key_col = 2'd1;
    tick();
    new_game = 0; key_valid = 0;
    chk("ab_core_reset", {7'b0, core_bus.core_reset}, 8'h01);
    chk("ab_count", {4'b0, move_count}, 8'h00);
    tick(); tick(); tick();
    chk("ab_busy", {7'b0, busy}, 8'h00);

    // Ten accepted moves: count saturates at 9
    mk = 2'b01;
    for (int i = 0; i < 10; i++) begin
      play(2'(i % 3), 2'((i / 3) % 3), 1'b0, 2'b00, mk);
      mk = (mk == 2'b01) ? 2'b10 : 2'b01;
      chk("sat_count", {4'b0, move_count}, (i >= 8) ? 8'd9 : 8'(i + 1));
      chk("sat_turn", {6'b0, turn}, {6'b0, mk});
    end

    // Reset in the middle of AI_WAIT
    new_game = 1; single_player = 1;
    tick();
    new_game = 0;
    tick();
    play(2'd2, 2'd2, 1'b0, 2'b00, 2'b01);
    tick();
    key_valid = 1; key_row = 2'd0; key_col = 2'd0;
    tick();
    key_valid = 0;
    chk("aw_drop", {7'b0, key_dropped}, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("mid_core_reset", {7'b0, core_bus.core_reset}, 8'h01);
    chk("mid_xoroin", {6'b0, core_bus.xoroin}, 8'h00);
    chk("mid_ai_en", {7'b0, core_bus.ai_en}, 8'h00);
    chk("mid_turn", {6'b0, turn}, 8'h01);
    chk("mid_busy", {7'b0, busy}, 8'h01);
    chk("mid_rej", {7'b0, move_rejected}, 8'h00);
    chk("mid_drop", {7'b0, key_dropped}, 8'h00);
    chk("mid_count", {4'b0, move_count}, 8'h00);
    #2 reset = 1'b1;
    tick();
    chk("post_busy", {7'b0, busy}, 8'h00);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
